// File: rtl/mem_arbiter_if.sv
// Requester and RAM-side signal bundle for the shared byte-serial memory arbiter.
interface mem_arbiter_if #(
   parameter int unsigned ADDR_W = 32
);
   // global control
   logic              rdy;
   logic              rollback;
   // committed store from the ROB
   logic              store_req;
   logic [1:0]        store_size;
   logic [ADDR_W-1:0] store_addr;
   logic [31:0]       store_data;
   logic              store_begin;
   logic              store_done;
   // load from the LSB
   logic              load_req;
   logic [1:0]        load_size;
   logic              load_signed;
   logic [ADDR_W-1:0] load_addr;
   logic              load_done;
   logic [31:0]       load_data;
   // instruction fetch
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_done;
   logic [31:0]       if_inst;
   // byte-wide RAM port
   logic [ADDR_W-1:0] mem_a;
   logic              mem_wr;
   logic [7:0]        mem_dout;
   logic [7:0]        mem_din;

   // requester / RAM side
   modport master (
      output rdy, rollback,
      output store_req, store_size, store_addr, store_data,
      input  store_begin, store_done,
      output load_req, load_size, load_signed, load_addr,
      input  load_done, load_data,
      output if_req, if_addr,
      input  if_done, if_inst,
      input  mem_a, mem_wr, mem_dout,
      output mem_din
   );

   // arbiter side
   modport slave (
      input  rdy, rollback,
      input  store_req, store_size, store_addr, store_data,
      output store_begin, store_done,
      input  load_req, load_size, load_signed, load_addr,
      output load_done, load_data,
      input  if_req, if_addr,
      output if_done, if_inst,
      output mem_a, mem_wr, mem_dout,
      input  mem_din
   );
endinterface

// File: rtl/mem_arbiter.sv
// Byte-serial RAM arbiter: store > load > ifetch, one byte per cycle, extended read results.
module mem_arbiter #(
   parameter int unsigned ADDR_W = 32
) (
   input  logic         clk,
   input  logic         rst,
   mem_arbiter_if.slave bus
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_READ  = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;

   localparam logic OWN_LOAD = 1'b0;
   localparam logic OWN_IF   = 1'b1;

   localparam int unsigned CNT_W = 3;

   logic [1:0]        state_q,       state_d;
   logic              owner_q,       owner_d;
   logic [CNT_W-1:0]  cnt_q,         cnt_d;
   logic [CNT_W-1:0]  len_q,         len_d;
   logic              sgn_q,         sgn_d;
   logic [ADDR_W-1:0] addr_q,        addr_d;
   logic [31:0]       wdata_q,       wdata_d;
   logic [31:0]       rbuf_q,        rbuf_d;
   logic [ADDR_W-1:0] mem_a_q,       mem_a_d;
   logic              mem_wr_q,      mem_wr_d;
   logic [7:0]        mem_dout_q,    mem_dout_d;
   logic              store_begin_q, store_begin_d;
   logic              store_done_q,  store_done_d;
   logic              load_done_q,   load_done_d;
   logic [31:0]       load_data_q,   load_data_d;
   logic              if_done_q,     if_done_d;
   logic [31:0]       if_inst_q,     if_inst_d;

   logic [CNT_W-1:0]  cnt_inc_c;
   logic [CNT_W-1:0]  cnt_dec_c;

   // size code to byte count; code 3 behaves as a word
   function automatic logic [CNT_W-1:0] size_len(input logic [1:0] size);
      logic [CNT_W-1:0] n;
      case (size)
         2'd0:    n = CNT_W'(1);
         2'd1:    n = CNT_W'(2);
         default: n = CNT_W'(4);
      endcase
      return n;
   endfunction

   // sign/zero extension of an assembled little-endian value of len bytes
   function automatic logic [31:0] extend(input logic [31:0] w, input logic [CNT_W-1:0] len,
                                          input logic sgn);
      logic [31:0] r;
      case (len)
         CNT_W'(1): r = {{24{sgn & w[7]}}, w[7:0]};
         CNT_W'(2): r = {{16{sgn & w[15]}}, w[15:0]};
         default:   r = w;
      endcase
      return r;
   endfunction

   assign cnt_inc_c = cnt_q + CNT_W'(1);
   assign cnt_dec_c = cnt_q - CNT_W'(1);

   // next-state and next-output decode
   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      cnt_d         = cnt_q;
      len_d         = len_q;
      sgn_d         = sgn_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      rbuf_d        = rbuf_q;
      mem_a_d       = mem_a_q;
      mem_wr_d      = mem_wr_q;
      mem_dout_d    = mem_dout_q;
      store_begin_d = 1'b0;
      store_done_d  = 1'b0;
      load_done_d   = 1'b0;
      load_data_d   = load_data_q;
      if_done_d     = 1'b0;
      if_inst_d     = if_inst_q;

      case (state_q)
         S_IDLE: begin
            // a requester whose done pulse is still showing is not re-granted this cycle
            if (bus.store_req && !store_done_q) begin
               state_d       = S_WRITE;
               addr_d        = bus.store_addr;
               len_d         = size_len(bus.store_size);
               wdata_d       = bus.store_data;
               cnt_d         = '0;
               mem_a_d       = bus.store_addr;
               mem_wr_d      = 1'b1;
               mem_dout_d    = bus.store_data[7:0];
               store_begin_d = 1'b1;
            end else if (bus.load_req && !bus.rollback && !load_done_q) begin
               state_d  = S_READ;
               owner_d  = OWN_LOAD;
               addr_d   = bus.load_addr;
               len_d    = size_len(bus.load_size);
               sgn_d    = bus.load_signed;
               cnt_d    = '0;
               rbuf_d   = '0;
               mem_a_d  = bus.load_addr;
               mem_wr_d = 1'b0;
            end else if (bus.if_req && !bus.rollback && !if_done_q) begin
               state_d  = S_READ;
               owner_d  = OWN_IF;
               addr_d   = bus.if_addr;
               len_d    = CNT_W'(4);
               sgn_d    = 1'b0;
               cnt_d    = '0;
               rbuf_d   = '0;
               mem_a_d  = bus.if_addr;
               mem_wr_d = 1'b0;
            end
         end

         S_WRITE: begin
            // cnt_q is the byte currently on the bus; rollback cannot stop a committed store
            if (cnt_inc_c < len_q) begin
               cnt_d      = cnt_inc_c;
               mem_a_d    = addr_q + ADDR_W'(cnt_inc_c);
               mem_dout_d = wdata_q[{cnt_inc_c[1:0], 3'b000} +: 8];
            end else begin
               state_d      = S_IDLE;
               cnt_d        = '0;
               mem_wr_d     = 1'b0;
               store_done_d = 1'b1;
            end
         end

         S_READ: begin
            if (bus.rollback) begin
               state_d = S_IDLE;
               cnt_d   = '0;
               rbuf_d  = '0;
            end else begin
               // mem_din carries the byte addressed one cycle earlier
               if (cnt_q != '0) begin
                  rbuf_d[{cnt_dec_c[1:0], 3'b000} +: 8] = bus.mem_din;
               end
               if (cnt_q == len_q) begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
                  if (owner_q == OWN_LOAD) begin
                     load_done_d = 1'b1;
                     load_data_d = extend(rbuf_d, len_q, sgn_q);
                  end else begin
                     if_done_d = 1'b1;
                     if_inst_d = rbuf_d;
                  end
               end else begin
                  cnt_d = cnt_inc_c;
                  if (cnt_inc_c < len_q) begin
                     mem_a_d = addr_q + ADDR_W'(cnt_inc_c);
                  end
               end
            end
         end

         default: begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            mem_wr_d = 1'b0;
         end
      endcase
   end

   // state and output registers; rdy low freezes everything
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         owner_q       <= OWN_LOAD;
         cnt_q         <= '0;
         len_q         <= '0;
         sgn_q         <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         rbuf_q        <= '0;
         mem_a_q       <= '0;
         mem_wr_q      <= 1'b0;
         mem_dout_q    <= '0;
         store_begin_q <= 1'b0;
         store_done_q  <= 1'b0;
         load_done_q   <= 1'b0;
         load_data_q   <= '0;
         if_done_q     <= 1'b0;
         if_inst_q     <= '0;
      end else if (bus.rdy) begin
         state_q       <= state_d;
         owner_q       <= owner_d;
         cnt_q         <= cnt_d;
         len_q         <= len_d;
         sgn_q         <= sgn_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         rbuf_q        <= rbuf_d;
         mem_a_q       <= mem_a_d;
         mem_wr_q      <= mem_wr_d;
         mem_dout_q    <= mem_dout_d;
         store_begin_q <= store_begin_d;
         store_done_q  <= store_done_d;
         load_done_q   <= load_done_d;
         load_data_q   <= load_data_d;
         if_done_q     <= if_done_d;
         if_inst_q     <= if_inst_d;
      end
   end

   assign bus.mem_a       = mem_a_q;
   assign bus.mem_wr      = mem_wr_q;
   assign bus.mem_dout    = mem_dout_q;
   assign bus.store_begin = store_begin_q;
   assign bus.store_done  = store_done_q;
   assign bus.load_done   = load_done_q;
   assign bus.load_data   = load_data_q;
   assign bus.if_done     = if_done_q;
   assign bus.if_inst     = if_inst_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed corner cases plus randomized request mixes.
module tb_mem_arbiter;
   localparam int K_STORE = 0;
   localparam int K_LOAD  = 1;
   localparam int K_IF    = 2;

   typedef struct {
      int          kind;
      logic [31:0] data;
   } exp_t;

   logic clk;
   logic rst;
   logic rdy_q;
   logic [7:0] mem_din_r;

   int n_checks;
   int n_errors;

   exp_t exp_q[$];
   logic [7:0] ram     [logic [31:0]];
   logic [7:0] ref_mem [logic [31:0]];

   mem_arbiter_if #(.ADDR_W(32)) bus ();

   mem_arbiter #(.ADDR_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // power-on contents shared by the RAM and the reference memory
   function automatic logic [7:0] init_byte(input logic [31:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h5A;
   endfunction

   function automatic logic [7:0] ram_rd(input logic [31:0] a);
      if (ram.exists(a)) return ram[a];
      return init_byte(a);
   endfunction

   function automatic logic [7:0] ref_rd(input logic [31:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return init_byte(a);
   endfunction

   // RAM model: synchronous read, frozen by rdy like the arbiter
   always @(posedge clk) begin
      if (bus.rdy) begin
         if (bus.mem_wr) ram[bus.mem_a] = bus.mem_dout;
         mem_din_r <= ram_rd(bus.mem_a);
      end
   end
   assign bus.mem_din = mem_din_r;

   always @(posedge clk) rdy_q <= bus.rdy;

   function automatic string kname(input int k);
      if (k == K_STORE) return "STORE";
      if (k == K_LOAD)  return "LOAD";
      return "IF";
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
      end
   endtask

   // reference model: byte count, little-endian assembly, extension from the top byte read
   function automatic logic [31:0] ref_read(input logic [31:0] a, input logic [1:0] sz,
                                           input logic sgn);
      int n;
      logic [31:0] w;
      n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      w = 32'h0;
      for (int k = 0; k < n; k++) w = w | (32'(ref_rd(a + 32'(k))) << (8 * k));
      if (n < 4 && sgn && w[8*n-1]) w = w | (32'hFFFF_FFFF << (8 * n));
      return w;
   endfunction

   task automatic exp_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
      int n;
      n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      for (int k = 0; k < n; k++) ref_mem[a + 32'(k)] = d[8*k +: 8];
      exp_q.push_back('{K_STORE, 32'h0});
   endtask

   task automatic exp_load(input logic [31:0] a, input logic [1:0] sz, input logic sgn);
      exp_q.push_back('{K_LOAD, ref_read(a, sz, sgn)});
   endtask

   task automatic exp_if(input logic [31:0] a);
      exp_q.push_back('{K_IF, ref_read(a, 2'd2, 1'b0)});
   endtask

   task automatic poke(input logic [31:0] a, input logic [7:0] v);
      ram[a]     = v;
      ref_mem[a] = v;
   endtask

   task automatic pop_cmp(input int kind, input logic [31:0] data);
      exp_t e;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL unexpected_done: got %s pulse, required none", kname(kind));
         return;
      end
      e = exp_q.pop_front();
      chk({"done_kind_", kname(kind)}, 32'(kind), 32'(e.kind));
      if (kind != K_STORE) chk({"done_data_", kname(kind)}, data, e.data);
   endtask

   // monitor: every freshly raised done pulse is matched against the scoreboard
   always @(negedge clk) begin
      int np;
      if (rst !== 1'b1 && rdy_q === 1'b1) begin
         np = int'(bus.store_done) + int'(bus.load_done) + int'(bus.if_done);
         if (np > 0) begin
            chk("single_done_pulse", 32'(np), 32'd1);
            if (bus.store_done) pop_cmp(K_STORE, 32'h0);
            if (bus.load_done)  pop_cmp(K_LOAD, bus.load_data);
            if (bus.if_done)    pop_cmp(K_IF, bus.if_inst);
         end
      end
   end

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [31:0] rand_addr();
      if ($urandom_range(0, 3) == 0) return 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      return 32'($urandom_range(0, 63));
   endfunction

   // one random mix of simultaneous requests with random rdy stalls
   task automatic do_round(input int idx);
      bit ds, dl, di, fin;
      logic [1:0] ssz, lsz;
      logic [31:0] sa, sd, la, ia;
      logic lsg;
      int n;
      ds = 1'($urandom_range(0, 1));
      dl = 1'($urandom_range(0, 1));
      di = 1'($urandom_range(0, 1));
      if (!ds && !dl && !di) dl = 1'b1;
      ssz = 2'($urandom_range(0, 3));
      lsz = 2'($urandom_range(0, 3));
      lsg = 1'($urandom_range(0, 1));
      sa = rand_addr();
      sd = $urandom;
      la = rand_addr();
      ia = rand_addr();
      if (ds) exp_store(sa, ssz, sd);
      if (dl) exp_load(la, lsz, lsg);
      if (di) exp_if(ia);
      bus.store_req = ds; bus.store_size = ssz; bus.store_addr = sa; bus.store_data = sd;
      bus.load_req = dl;  bus.load_size = lsz;  bus.load_addr = la;  bus.load_signed = lsg;
      bus.if_req = di;    bus.if_addr = ia;
      fin = 1'b0;
      for (int c = 0; c < 300 && !fin; c++) begin
         @(negedge clk);
         if (bus.store_done) bus.store_req = 1'b0;
         if (bus.load_done)  bus.load_req  = 1'b0;
         if (bus.if_done)    bus.if_req    = 1'b0;
         bus.rdy = ($urandom_range(0, 4) != 0);
         fin = !bus.store_req && !bus.load_req && !bus.if_req;
      end
      bus.rdy = 1'b1;
      if (!fin) $display("FAIL round_timeout: round %0d still pending after 300 cycles, required completion", idx);
      n_checks++;
      if (!fin) n_errors++;
      wait_neg(2);
      chk("round_queue_empty", 32'(exp_q.size()), 32'd0);
      if (ds) begin
         n = (ssz == 2'd0) ? 1 : (ssz == 2'd1) ? 2 : 4;
         for (int k = 0; k < n; k++) chk("round_ram_byte", 32'(ram_rd(sa + 32'(k))), 32'(ref_rd(sa + 32'(k))));
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int ts, tl, ti;
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      bus.rdy = 1'b1; bus.rollback = 1'b0;
      bus.store_req = 1'b0; bus.store_size = 2'd0; bus.store_addr = '0; bus.store_data = '0;
      bus.load_req = 1'b0; bus.load_size = 2'd0; bus.load_signed = 1'b0; bus.load_addr = '0;
      bus.if_req = 1'b0; bus.if_addr = '0;

      // reset values
      wait_neg(2);
      chk("rst_mem_a", bus.mem_a, 32'h0);
      chk("rst_mem_wr", 32'(bus.mem_wr), 32'h0);
      chk("rst_mem_dout", 32'(bus.mem_dout), 32'h0);
      chk("rst_store_begin", 32'(bus.store_begin), 32'h0);
      chk("rst_store_done", 32'(bus.store_done), 32'h0);
      chk("rst_load_done", 32'(bus.load_done), 32'h0);
      chk("rst_load_data", bus.load_data, 32'h0);
      chk("rst_if_done", 32'(bus.if_done), 32'h0);
      chk("rst_if_inst", bus.if_inst, 32'h0);
      rst = 1'b0;
      wait_neg(2);
      chk("idle_mem_wr", 32'(bus.mem_wr), 32'h0);

      // SW 0x100 <- 0xDEADBEEF
      exp_store(32'h100, 2'd2, 32'hDEAD_BEEF);
      bus.store_req = 1'b1; bus.store_size = 2'd2; bus.store_addr = 32'h100; bus.store_data = 32'hDEAD_BEEF;
      wait_neg(1);
      chk("sw_begin", 32'(bus.store_begin), 32'h1);
      chk("sw_wr0", 32'(bus.mem_wr), 32'h1);
      chk("sw_a0", bus.mem_a, 32'h100);
      chk("sw_d0", 32'(bus.mem_dout), 32'hEF);
      for (int k = 1; k < 4; k++) begin
         logic [31:0] dw;
         dw = 32'hDEAD_BEEF;
         wait_neg(1);
         chk("sw_begin_once", 32'(bus.store_begin), 32'h0);
         chk("sw_wr", 32'(bus.mem_wr), 32'h1);
         chk("sw_a", bus.mem_a, 32'h100 + 32'(k));
         chk("sw_d", 32'(bus.mem_dout), 32'(dw[8*k +: 8]));
         chk("sw_not_done", 32'(bus.store_done), 32'h0);
      end
      wait_neg(1);
      chk("sw_done_t5", 32'(bus.store_done), 32'h1);
      chk("sw_wr_off", 32'(bus.mem_wr), 32'h0);
      bus.store_req = 1'b0;
      wait_neg(1);

      // LB / LBU at 0x20 holding 0x80
      poke(32'h20, 8'h80);
      for (int s = 1; s >= 0; s--) begin
         exp_load(32'h20, 2'd0, 1'(s));
         bus.load_req = 1'b1; bus.load_size = 2'd0; bus.load_signed = 1'(s); bus.load_addr = 32'h20;
         wait_neg(1);
         chk("lb_a", bus.mem_a, 32'h20);
         chk("lb_rd", 32'(bus.mem_wr), 32'h0);
         wait_neg(1);
         chk("lb_not_done_t2", 32'(bus.load_done), 32'h0);
         wait_neg(1);
         chk("lb_done_t3", 32'(bus.load_done), 32'h1);
         chk("lb_data", bus.load_data, (s == 1) ? 32'hFFFF_FF80 : 32'h0000_0080);
         bus.load_req = 1'b0;
         wait_neg(1);
         chk("lb_data_hold", bus.load_data, (s == 1) ? 32'hFFFF_FF80 : 32'h0000_0080);
      end

      // LH signed wrapping past the top of the address space
      poke(32'hFFFF_FFFF, 8'h34);
      poke(32'h0, 8'h92);
      exp_load(32'hFFFF_FFFF, 2'd1, 1'b1);
      bus.load_req = 1'b1; bus.load_size = 2'd1; bus.load_signed = 1'b1; bus.load_addr = 32'hFFFF_FFFF;
      wait_neg(1);
      chk("lh_a0", bus.mem_a, 32'hFFFF_FFFF);
      wait_neg(1);
      chk("lh_a1_wrap", bus.mem_a, 32'h0);
      wait_neg(2);
      chk("lh_done_t4", 32'(bus.load_done), 32'h1);
      chk("lh_data", bus.load_data, 32'hFFFF_9234);
      bus.load_req = 1'b0;
      wait_neg(1);

      // all three requesters at once
      exp_store(32'h40, 2'd2, 32'hCAFE_F00D);
      exp_load(32'h40, 2'd2, 1'b0);
      exp_if(32'h40);
      bus.store_req = 1'b1; bus.store_size = 2'd2; bus.store_addr = 32'h40; bus.store_data = 32'hCAFE_F00D;
      bus.load_req = 1'b1; bus.load_size = 2'd2; bus.load_signed = 1'b0; bus.load_addr = 32'h40;
      bus.if_req = 1'b1; bus.if_addr = 32'h40;
      ts = -1; tl = -1; ti = -1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (bus.store_done && ts < 0) begin ts = c; bus.store_req = 1'b0; end
         if (bus.load_done && tl < 0) begin tl = c; bus.load_req = 1'b0; end
         if (bus.if_done && ti < 0) begin ti = c; bus.if_req = 1'b0; end
         if (ts >= 0 && tl >= 0 && ti >= 0) break;
      end
      chk("prio_store_cycle", 32'(ts), 32'd5);
      chk("prio_load_cycle", 32'(tl), 32'd11);
      chk("prio_if_cycle", 32'(ti), 32'd17);
      bus.store_req = 1'b0; bus.load_req = 1'b0; bus.if_req = 1'b0;
      wait_neg(1);

      // rollback at byte 2 of a fetch; a load takes the bus straight after
      bus.if_req = 1'b1; bus.if_addr = 32'h40;
      wait_neg(3);
      chk("rb_if_a2", bus.mem_a, 32'h42);
      exp_load(32'h21, 2'd0, 1'b0);
      bus.rollback = 1'b1; bus.if_req = 1'b0;
      bus.load_req = 1'b1; bus.load_size = 2'd0; bus.load_signed = 1'b0; bus.load_addr = 32'h21;
      wait_neg(1);
      bus.rollback = 1'b0;
      chk("rb_if_no_done_t4", 32'(bus.if_done), 32'h0);
      wait_neg(1);
      chk("rb_load_a_t5", bus.mem_a, 32'h21);
      wait_neg(1);
      chk("rb_if_no_done_t6", 32'(bus.if_done), 32'h0);
      wait_neg(1);
      chk("rb_load_done_t7", 32'(bus.load_done), 32'h1);
      bus.load_req = 1'b0;
      wait_neg(1);

      // rollback alongside a store in IDLE and during its writes
      exp_store(32'h200, 2'd2, 32'h1188_3344);
      exp_load(32'h202, 2'd0, 1'b1);
      bus.store_req = 1'b1; bus.store_size = 2'd2; bus.store_addr = 32'h200; bus.store_data = 32'h1188_3344;
      bus.load_req = 1'b1; bus.load_size = 2'd0; bus.load_signed = 1'b1; bus.load_addr = 32'h202;
      bus.rollback = 1'b1;
      wait_neg(1);
      chk("rbw_begin", 32'(bus.store_begin), 32'h1);
      chk("rbw_wr", 32'(bus.mem_wr), 32'h1);
      wait_neg(2);
      bus.rollback = 1'b0;
      wait_neg(2);
      chk("rbw_done_t5", 32'(bus.store_done), 32'h1);
      bus.store_req = 1'b0;
      wait_neg(3);
      chk("rbw_load_done_t8", 32'(bus.load_done), 32'h1);
      chk("rbw_load_data", bus.load_data, 32'hFFFF_FF88);
      bus.load_req = 1'b0;
      chk("rbw_ram_top", 32'(ram_rd(32'h203)), 32'h11);
      wait_neg(1);

      // rdy low for three cycles in the middle of a word load
      exp_load(32'h100, 2'd2, 1'b1);
      bus.load_req = 1'b1; bus.load_size = 2'd2; bus.load_signed = 1'b1; bus.load_addr = 32'h100;
      wait_neg(3);
      chk("frz_a_before", bus.mem_a, 32'h102);
      bus.rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         wait_neg(1);
         chk("frz_a_hold", bus.mem_a, 32'h102);
         chk("frz_wr_hold", 32'(bus.mem_wr), 32'h0);
         chk("frz_no_done", 32'(bus.load_done), 32'h0);
      end
      bus.rdy = 1'b1;
      wait_neg(2);
      chk("frz_not_done_t8", 32'(bus.load_done), 32'h0);
      wait_neg(1);
      chk("frz_done_t9", 32'(bus.load_done), 32'h1);
      chk("frz_data", bus.load_data, 32'hDEAD_BEEF);
      bus.load_req = 1'b0;
      wait_neg(1);

      // randomized request mixes
      for (int r = 0; r < 40; r++) do_round(r);

      // asynchronous reset in the middle of a word store
      bus.store_req = 1'b1; bus.store_size = 2'd2; bus.store_addr = 32'h3000; bus.store_data = 32'hA1B2_C3D4;
      wait_neg(2);
      #1 rst = 1'b1;
      #1;
      chk("arst_mem_wr", 32'(bus.mem_wr), 32'h0);
      chk("arst_mem_a", bus.mem_a, 32'h0);
      chk("arst_mem_dout", 32'(bus.mem_dout), 32'h0);
      exp_q.delete();
      bus.store_req = 1'b0;
      wait_neg(1);
      rst = 1'b0;
      wait_neg(2);
      chk("arst_byte0_written", 32'(ram_rd(32'h3000)), 32'hD4);
      chk("arst_byte1_untouched", 32'(ram_rd(32'h3001)), 32'(init_byte(32'h3001)));
      chk("arst_byte3_untouched", 32'(ram_rd(32'h3003)), 32'(init_byte(32'h3003)));
      chk("arst_no_done", 32'(bus.store_done), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
